// File: rtl/conv3x3_mac_if.sv
// Bus bundle for conv3x3_mac: window/weight inputs and the result strobe.
// The master side drives windows, weights and clear; the slave side is the MAC.
interface conv3x3_mac_if;
    logic [71:0]        image_in;
    logic               win_valid;
    logic               clear;
    logic               weight_we;
    logic [3:0]         weight_addr;
    logic [7:0]         weight_in;
    logic signed [31:0] out_data;
    logic               out_valid;

    modport master (
        output image_in, win_valid, clear, weight_we, weight_addr, weight_in,
        input  out_data, out_valid
    );

    modport slave (
        input  image_in, win_valid, clear, weight_we, weight_addr, weight_in,
        output out_data, out_valid
    );
endinterface

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 convolution MAC over NUM_CH consecutive windows.
// Pipeline: products (edge t) -> partial sum (t+1) -> accumulator (t+2)
// -> registered result and one-cycle strobe (t+3).
// Optional feature: define CONV_RELU_EN to clamp negative results to zero.
module conv3x3_mac #(
    parameter int NUM_CH = 4
) (
    input  logic          clk,
    input  logic          rst,
    conv3x3_mac_if.slave  bus
);

    logic signed [7:0]  weight_q [9];
    logic signed [16:0] prod_d [9];
    logic signed [16:0] prod_q [9];
    logic signed [20:0] sum_d, sum_q;
    logic signed [31:0] acc_d, acc_q;
    logic signed [31:0] out_data_d, out_data_q;
    logic [3:0]         ch_d, ch_q;
    logic               v1_q, v2_q, v3_q;
    logic               first1_q, first2_q;
    logic               last1_q, last2_q, last3_q;
    logic               out_valid_q;
    logic               accept;
    logic               fire;

    assign accept = bus.win_valid & ~bus.clear;
    assign fire   = v3_q & last3_q & ~bus.clear;

    // Weight file: written on weight_we, addresses 9..15 ignored.
    // NOTE: the register file is reset because a cleared weight set is part of the reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 9; k++) weight_q[k] <= '0;
        end else if (bus.weight_we && bus.weight_addr < 4'd9) begin
            weight_q[bus.weight_addr] <= bus.weight_in;
        end
    end

    // Products, partial sum, accumulator, channel counter and final result.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum_d      = '0;
        acc_d      = acc_q;
        ch_d       = ch_q;
        out_data_d = acc_q;
        for (int k = 0; k < 9; k++) begin
            prod_d[k] = $signed({9'b0, bus.image_in[71-8*k -: 8]})
                      * $signed({{9{weight_q[k][7]}}, weight_q[k]});
        end
        // NOTE: blocking '=' here is intentional: it chains the adder tree combinationally.
        for (int k = 0; k < 9; k++) begin
            sum_d = sum_d + {{4{prod_q[k][16]}}, prod_q[k]};
        end
        if (first2_q) acc_d = {{11{sum_q[20]}}, sum_q};
        else          acc_d = acc_q + {{11{sum_q[20]}}, sum_q};
        if (bus.clear)   ch_d = '0;
        else if (accept) ch_d = (ch_q == 4'(NUM_CH - 1)) ? 4'd0 : ch_q + 4'd1;
`ifdef CONV_RELU_EN
        out_data_d = acc_q[31] ? 32'sd0 : acc_q;
`else
        out_data_d = acc_q;
`endif
    end

    // Pipeline registers with a valid bit per stage; clear kills in-flight work.
    // NOTE: sequential state uses non-blocking '<=' so all stages advance on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 9; k++) prod_q[k] <= '0;
            sum_q       <= '0;
            acc_q       <= '0;
            ch_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            first1_q    <= 1'b0;
            first2_q    <= 1'b0;
            last1_q     <= 1'b0;
            last2_q     <= 1'b0;
            last3_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ch_q <= ch_d;
            // Stage 1: products of the accepted window.
            v1_q <= accept;
            if (accept) begin
                for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
                first1_q <= (ch_q == 4'd0);
                last1_q  <= (ch_q == 4'(NUM_CH - 1));
            end
            // Stage 2: partial sum.
            v2_q <= v1_q & ~bus.clear;
            if (v1_q) begin
                sum_q    <= sum_d;
                first2_q <= first1_q;
                last2_q  <= last1_q;
            end
            // Stage 3: accumulate across channels.
            v3_q <= v2_q & ~bus.clear;
            if (v2_q) begin
                acc_q   <= acc_d;
                last3_q <= last2_q;
            end
            // Output: registered result held between strobes.
            out_valid_q <= fire;
            if (fire) out_data_q <= out_data_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: doc/conv3x3_mac.md
CONV3X3_MAC -- requirements
Module: conv3x3_mac

Interface
REQ-001 Parameter: NUM_CH, 4, number of consecutive valid windows accumulated per result (legal 1..16).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: image_in  input  72  3x3 window of unsigned 8-bit pixels; pixel k (k=0..8) = image_in[71-8k -: 8].
REQ-005 Port: win_valid  input  1  image_in valid this cycle.
REQ-006 Port: clear  input  1  synchronous flush of accumulation and pipeline.
REQ-007 Port: weight_we  input  1  weight write strobe.
REQ-008 Port: weight_addr  input  4  weight index 0..8.
REQ-009 Port: weight_in  input  8  signed two's-complement weight.
REQ-010 Port: out_data  output  32  signed accumulated convolution result.
REQ-011 Port: out_valid  output  1  one-cycle result strobe.

Function
REQ-012 Weight file SHALL hold 9 signed 8-bit registers, written on a rising edge when weight_we=1; weight_addr 9..15 SHALL be ignored.
REQ-013 A window sampled on the same edge as a weight write SHALL use the pre-write weight; later windows use the new one.
REQ-014 Stage 1: on an edge with win_valid=1, 9 products SHALL be registered, pixel zero-extended to 9 bits times signed weight, 17-bit signed each.
REQ-015 Stage 2: next edge, the 9 products SHALL be summed into a registered 21-bit signed partial sum.
REQ-016 Stage 3: next edge, the partial SHALL be added to a 32-bit signed accumulator; on the first channel of a group it SHALL load the partial instead of adding.
REQ-017 A channel counter 0..NUM_CH-1 SHALL advance only on accepted windows and wrap to 0 after NUM_CH-1.
REQ-018 When the final (NUM_CH-th) window's partial reaches stage 3, out_data SHALL update and out_valid SHALL be 1 for exactly one cycle, 3 edges after the edge that sampled that window.
REQ-019 out_data SHALL hold its value between strobes; out_valid=0 otherwise.
REQ-020 Gaps in win_valid SHALL be permitted; each stage carries its own valid bit; no backpressure exists.
REQ-021 Back-to-back windows SHALL be accepted every cycle with full throughput; with NUM_CH=1 every window produces a strobe.
REQ-022 clear=1 SHALL zero the channel counter and all stage valid bits on that edge; a window presented with clear=1 SHALL be discarded; weights SHALL be retained.
REQ-023 clear SHALL suppress any out_valid that would have occurred in the 3 cycles after it.
REQ-024 Sign extension SHALL be used at every width increase; no overflow is possible for NUM_CH<=16.

Reset
REQ-025 rst=0 SHALL immediately clear weights, products, partial sum, accumulator, channel counter, valid bits, out_data=0, out_valid=0.
REQ-026 Reset mid-accumulation SHALL discard the partial group; first window after release starts channel 0.

Configuration
REQ-027 Macro CONV_RELU_EN: when defined, a result SHALL be registered to out_data as 0 if negative, else unchanged; when undefined, out_data SHALL carry the raw signed sum. Latency is identical in both builds.

Verification
REQ-028 Reset: assert rst=0 mid-stream -> out_valid=0, out_data=0 immediately; all-zero weights, window 0xFF.. -> out_data=0.
REQ-029 NUM_CH=1, weights all 1, image_in all 8'hFF at edge t -> out_data=2295, out_valid pulse exactly at t+3.
REQ-030 NUM_CH=4, weights all 8'h80, four consecutive all-0xFF windows -> out_data=-1175040 (raw) or 0 with CONV_RELU_EN; single strobe.
REQ-031 NUM_CH=4, weights all 1, four valid windows of all 8'h01 separated by random idle cycles -> one strobe with out_data=36, 3 edges after 4th window.
REQ-032 Two windows, then clear, then four windows of all 8'h02 (weights 1) -> no strobe from first pair; single strobe with out_data=72.
REQ-033 Weight 0 written 1->5 on same edge as window w0 (pixel0=10, others 0), next window w1 identical, NUM_CH=1 -> results 10 then 50.
